vga_pattern_gen: RTL

VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

---
 rtl/vga_pattern_gen.sv | 135 +++++++++++++
 1 files changed

// File: rtl/vga_pattern_gen.sv
// rtl/vga_pattern_gen.sv - VGA timing generator with colour-bar and scrolling checkerboard test patterns
// Optional one-pixel white frame around the visible area: define VGA_PATTERN_GEN_BORDER_EN.
module vga_pattern_gen #(
   parameter int   H_ACTIVE  = 640,
   parameter int   H_FP      = 16,
   parameter int   H_SYNC    = 96,
   parameter int   H_BP      = 48,
   parameter int   V_ACTIVE  = 480,
   parameter int   V_FP      = 10,
   parameter int   V_SYNC    = 2,
   parameter int   V_BP      = 33,
   parameter int   CLK_DIV   = 2,
   parameter int   COLOR_W   = 1,
   parameter int   BAR_COUNT = 8,
   parameter logic SYNC_POL  = 1'b0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [1:0]         mode,
   output logic               hsync,
   output logic               vsync,
   output logic               de,
   output logic [COLOR_W-1:0] red,
   output logic [COLOR_W-1:0] green,
   output logic [COLOR_W-1:0] blue,
   output logic               frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL + 1);
   localparam int VW      = $clog2(V_TOTAL + 1);
   localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BAR_W   = H_ACTIVE / BAR_COUNT;
   localparam int BAR_H   = V_ACTIVE / BAR_COUNT;

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_VIS  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_MAX  = HW'(H_ACTIVE - 1);
   localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_VIS  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_MAX  = VW'(V_ACTIVE - 1);
   localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

   logic [DW-1:0] div_cnt;
   logic          pe;
   logic [HW-1:0] hcount;
   logic [VW-1:0] vcount;
   logic [7:0]    fcnt;
   logic [1:0]    mode_q;
   logic [1:0]    mode_eff;
   logic          at_origin;
   logic          visible;
   logic          hsync_d;
   logic          vsync_d;
   logic [2:0]    vb_code;
   logic [2:0]    hb_code;
   logic [2:0]    code;
   logic [4:0]    chk_sum;

   assign pe = (div_cnt == DW'(CLK_DIV - 1));

   // Mode is taken straight from the input on the first pixel so that pixel already shows the new pattern.
   always_comb begin
      at_origin = (hcount == '0) && (vcount == '0);
      mode_eff  = at_origin ? mode : mode_q;
      visible   = (hcount < H_VIS) && (vcount < V_VIS);
      hsync_d   = ((hcount >= HS_BEG) && (hcount < HS_END)) ? SYNC_POL : ~SYNC_POL;
      vsync_d   = ((vcount >= VS_BEG) && (vcount < VS_END)) ? SYNC_POL : ~SYNC_POL;
      vb_code   = 3'd7 - 3'(hcount / HW'(BAR_W));
      hb_code   = 3'd7 - 3'(vcount / VW'(BAR_H));
      chk_sum   = hcount[4:0] + fcnt[4:0];
      code      = '0;
      case (mode_eff)
         2'd0:    code = hb_code;
         2'd1:    code = vb_code;
         2'd2:    code = vb_code ^ hb_code;
         default: code = {3{chk_sum[4] ^ vcount[4]}};
      endcase
`ifdef VGA_PATTERN_GEN_BORDER_EN
      if ((hcount == '0) || (hcount == H_MAX) || (vcount == '0) || (vcount == V_MAX)) begin
         code = 3'b111;
      end
`endif
      if (!visible) begin
         code = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_cnt     <= '0;
         hcount      <= '0;
         vcount      <= '0;
         fcnt        <= '0;
         mode_q      <= '0;
         hsync       <= ~SYNC_POL;
         vsync       <= ~SYNC_POL;
         de          <= 1'b0;
         red         <= '0;
         green       <= '0;
         blue        <= '0;
         frame_start <= 1'b0;
      end else begin
         div_cnt     <= pe ? '0 : div_cnt + 1'b1;
         frame_start <= pe && at_origin;
         if (pe) begin
            hsync <= hsync_d;
            vsync <= vsync_d;
            de    <= visible;
            red   <= {COLOR_W{code[2]}};
            green <= {COLOR_W{code[1]}};
            blue  <= {COLOR_W{code[0]}};
            if (at_origin) begin
               mode_q <= mode;
            end
            if (hcount == H_LAST) begin
               hcount <= '0;
               if (vcount == V_LAST) begin
                  vcount <= '0;
                  fcnt   <= fcnt + 8'd1;
               end else begin
                  vcount <= vcount + 1'b1;
               end
            end else begin
               hcount <= hcount + 1'b1;
            end
         end
      end
   end

endmodule
